// File: rtl/gf_reduce_if.sv
// Request/result bundle between the carry-less multiplier and the gf_reduce stage.
// master: upstream requester; slave: the reduction stage.
interface gf_reduce_if #(
    parameter int DATA_WIDTH = 32
);
    localparam int WW = $clog2(DATA_WIDTH) + 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [WW-1:0]             in_width;
    logic [DATA_WIDTH-1:0]     in_poly;
    logic                      carry_option;
    logic [2*DATA_WIDTH-1:0]   in_product;
    logic [DATA_WIDTH-1:0]     out_result;
    logic                      out_valid;
    logic                      out_error;

    modport master (
        output in_valid, in_width, in_poly, carry_option, in_product,
        input  in_ready, out_result, out_valid, out_error
    );

    modport slave (
        input  in_valid, in_width, in_poly, carry_option, in_product,
        output in_ready, out_result, out_valid, out_error
    );
endinterface

// File: rtl/gf_reduce.sv
// Bit-serial GF(2^m) reduction of a double-width carry-less product modulo a
// runtime-selected field polynomial (x^m term implicit). One XOR step per cycle,
// from bit 2m-2 down to bit m, then a result strobe.
// Optional feature macro: GF_REDUCE_BYPASS_EN (carry_option=1 passes the low
// product word straight through, used for integer multiplies).
module gf_reduce #(
    parameter int DATA_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    gf_reduce_if.slave  bus
);
    localparam int WW  = $clog2(DATA_WIDTH) + 1;
    localparam int KW  = WW + 1;               // holds both in_width and 2m-2
    localparam int AW  = 2 * DATA_WIDTH - 1;   // accumulator width
    localparam int AIW = $clog2(AW);           // accumulator bit index width
    localparam int PW  = DATA_WIDTH + 1;       // polynomial incl. x^m term
    localparam logic [KW-1:0] MaxM = KW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StReduce,
        StDone
    } state_e;

    state_e                 r_state;
    logic [AW-1:0]          r_acc;
    logic [KW-1:0]          r_k;
    logic [KW-1:0]          r_m;
    logic [PW-1:0]          r_poly;
    logic                   r_bypass;
    logic                   r_illegal;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_valid;
    logic                   r_error;

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_illegal;
    logic                   w_bypass;
    logic [KW-1:0]          w_m;
    logic [AW-1:0]          w_load;
    logic [DATA_WIDTH-1:0]  w_pmask;
    logic [PW-1:0]          w_poly;
    logic [KW-1:0]          w_shamt;
    logic [AIW-1:0]         w_kidx;
    logic [AW-1:0]          w_step;
    logic [DATA_WIDTH-1:0]  w_result;

    assign w_ready   = (r_state == StIdle) || (r_state == StDone);
    assign w_accept  = bus.in_valid && w_ready;
    assign w_m       = KW'(bus.in_width);
    assign w_illegal = (w_m < KW'(2)) || (w_m > MaxM);

`ifdef GF_REDUCE_BYPASS_EN
    assign w_bypass = bus.carry_option;
`else
    // Integer mode is not built in; every request is reduced.
    logic w_unused_carry;
    assign w_unused_carry = bus.carry_option;
    assign w_bypass       = 1'b0;
`endif

    // Mask the incoming product to 2m-1 bits and the polynomial to m bits at capture.
    always_comb begin
        w_load  = '0;
        w_pmask = '0;
        for (int i = 0; i < AW; i++) begin
            w_load[i] = bus.in_product[i] && (i < 2 * int'(w_m) - 1);
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_pmask[i] = (i < int'(w_m));
        end
        if (w_bypass) begin
            w_load = bus.in_product[AW-1:0];
        end
    end

    // Implicit x^m term; a shift past the top (illegal m) simply yields zero.
    assign w_poly = {1'b0, bus.in_poly & w_pmask} | (PW'(1) << w_m);

    // One reduction step: cancel bit k with the polynomial aligned to k.
    assign w_shamt = r_k - r_m;
    assign w_kidx  = r_k[AIW-1:0];
    assign w_step  = r_acc[w_kidx] ? (r_acc ^ (AW'(r_poly) << w_shamt)) : r_acc;

    // Result selection: zero for illegal degree, raw low word for bypass, else low m bits.
    always_comb begin
        w_result = '0;
        if (r_illegal) begin
            w_result = '0;
        end else if (r_bypass) begin
            w_result = r_acc[DATA_WIDTH-1:0];
        end else begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                w_result[i] = r_acc[i] && (i < int'(r_m));
            end
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_poly    <= '0;
            r_bypass  <= 1'b0;
            r_illegal <= 1'b0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_error <= 1'b0;
            // The strobe is presented in the cycle after DONE.
            if (r_state == StDone) begin
                r_valid  <= 1'b1;
                r_error  <= r_illegal;
                r_result <= w_result;
            end
            case (r_state)
                StReduce: begin
                    r_acc <= w_step;
                    r_k   <= r_k - KW'(1);
                    if (r_k == r_m) begin
                        r_state <= StDone;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_acc     <= w_illegal ? '0 : w_load;
                        r_k       <= (w_m << 1) - KW'(2);
                        r_m       <= w_m;
                        r_poly    <= w_poly;
                        r_bypass  <= w_bypass;
                        r_illegal <= w_illegal;
                        r_state   <= (w_illegal || w_bypass) ? StDone : StReduce;
                    end else begin
                        r_state <= StIdle;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_result = r_result;
    assign bus.out_valid  = r_valid;
    assign bus.out_error  = r_error;
endmodule

// File: tb/tb_gf_reduce.sv
// Self-checking bench for gf_reduce: directed field vectors plus randomized
// requests checked against a field-multiplication reference model.
module tb_gf_reduce;
    localparam int DW = 32;
    localparam int WW = $clog2(DW) + 1;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    gf_reduce_if #(.DATA_WIDTH(DW)) bus ();

    gf_reduce #(.DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Carry-less product of two m-bit operands.
    function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p = '0;
        for (int i = 0; i < 32; i++) if (b[i]) p ^= (64'(a) << i);
        return p;
    endfunction

    // Field multiply a*b mod (x^m + poly) by shift-and-add with per-step xtime.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] poly, input int m);
        logic [63:0] mask = (64'd1 << m) - 64'd1;
        logic [63:0] aa   = 64'(a) & mask;
        logic [63:0] r    = '0;
        logic        top;
        for (int i = 0; i < m; i++) begin
            if (b[i]) r ^= aa;
            top = aa[m-1];
            aa  = (aa << 1) & mask;
            if (top) aa ^= (64'(poly) & mask);
        end
        return r[31:0];
    endfunction

    // Issue one request (called #1 after an edge) and measure accept-to-strobe cycles.
    task automatic do_req(input int m, input logic [31:0] poly, input logic [63:0] prod,
                          input logic carry, output logic [31:0] res, output logic err,
                          output int lat);
        int g = 0;
        bus.in_width     = WW'(m);
        bus.in_poly      = poly;
        bus.in_product   = prod;
        bus.carry_option = carry;
        bus.in_valid     = 1'b1;
        while (!bus.in_ready && g < 200) begin
            @(posedge clk); #1; g++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = -1; res = '0; err = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = c; res = bus.out_result; err = bus.out_error;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic seen = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_width = '0; bus.in_poly = '0;
        bus.in_product = '0; bus.carry_option = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_vec++; if (bus.out_error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", bus.out_error); end
        n_vec++; if (bus.out_result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", bus.out_result); end
        // rst and in_valid on the same edge: nothing may be accepted.
        rst = 1'b1; bus.in_valid = 1'b1; bus.in_width = WW'(1);
        @(posedge clk); #1;
        rst = 1'b0; bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_wins: got strobe %b want 0", seen); end
    endtask

    task automatic test_aes();
        logic [31:0] res; logic err; int lat;
        do_req(8, 32'h1B, 64'h2B79, 1'b0, res, err, lat);
        n_vec++; if (res !== 32'hC1) begin n_bad++; $display("FAIL aes_result: got %h want c1", res); end
        n_vec++; if (lat !== 8) begin n_bad++; $display("FAIL aes_latency: got %0d want 8", lat); end
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL aes_error: got %b want 0", err); end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        bus.in_width = WW'(4); bus.in_poly = 32'h3; bus.in_product = 64'h55;
        bus.carry_option = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_ready: got %b want 0", bus.in_ready); end
        // Second request held from now on; it is taken in the DONE cycle.
        bus.in_product = 64'h0F;
        while (t < 50) begin @(posedge clk); #1; t++; if (bus.out_valid) break; end
        bus.in_valid = 1'b0;
        n_vec++; if (t !== 4) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 4", t); end
        n_vec++; if (bus.out_result !== 32'hA) begin n_bad++; $display("FAIL b2b_first_result: got %h want a", bus.out_result); end
        t = 0;
        while (t < 50) begin @(posedge clk); #1; t++; if (bus.out_valid) break; end
        n_vec++; if (t !== 4) begin n_bad++; $display("FAIL b2b_spacing: got %0d want 4", t); end
        n_vec++; if (bus.out_result !== 32'hF) begin n_bad++; $display("FAIL b2b_second_result: got %h want f", bus.out_result); end
    endtask

    task automatic test_mask();
        logic [31:0] res; logic err; int lat;
        do_req(8, 32'h1B, 64'hFFFF_0005, 1'b0, res, err, lat);
        n_vec++; if (res !== 32'h05) begin n_bad++; $display("FAIL mask_result: got %h want 05", res); end
        n_vec++; if (lat !== 8) begin n_bad++; $display("FAIL mask_latency: got %0d want 8", lat); end
    endtask

    task automatic test_illegal();
        logic [31:0] res; logic err; int lat;
        int widths[3] = '{1, 33, 0};
        foreach (widths[j]) begin
            do_req(widths[j], 32'h1B, 64'h2B79, 1'b0, res, err, lat);
            n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL illegal_latency m=%0d: got %0d want 1", widths[j], lat); end
            n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_error m=%0d: got %b want 1", widths[j], err); end
            n_vec++; if (res !== 32'h0) begin n_bad++; $display("FAIL illegal_result m=%0d: got %h want 0", widths[j], res); end
        end
        @(posedge clk); #1;
        n_vec++; if (bus.out_error !== 1'b0) begin n_bad++; $display("FAIL illegal_error_drop: got %b want 0", bus.out_error); end
    endtask

    task automatic test_busy_ignore();
        int t = 0;
        bus.in_width = WW'(8); bus.in_poly = 32'h1B; bus.in_product = 64'h2B79;
        bus.carry_option = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_width = WW'(5); bus.in_poly = 32'hFF; bus.in_product = 64'hDEAD_BEEF_1234_5678;
        @(posedge clk); #1; t++;
        bus.in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; t++; if (bus.out_valid) break; end
        bus.in_valid = 1'b0;
        while (!bus.out_valid && t < 60) begin @(posedge clk); #1; t++; end
        n_vec++; if (t !== 8) begin n_bad++; $display("FAIL busy_latency: got %0d want 8", t); end
        n_vec++; if (bus.out_result !== 32'hC1) begin n_bad++; $display("FAIL busy_result: got %h want c1", bus.out_result); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, poly, res, exp_res; logic [63:0] prod, junk;
        logic carry, err; int m, lat, exp_lat;
        for (int it = 0; it < 24; it++) begin
            m     = $urandom_range(2, DW);
            a     = $urandom & ((m == 32) ? 32'hFFFF_FFFF : ((32'd1 << m) - 32'd1));
            b     = $urandom & ((m == 32) ? 32'hFFFF_FFFF : ((32'd1 << m) - 32'd1));
            poly  = $urandom;
            carry = 1'($urandom);
            junk  = {$urandom, $urandom};
            prod  = clmul(a, b) | (junk << (2 * m - 1));
            exp_res = gf_mul(a, b, poly, m);
            exp_lat = m;
`ifdef GF_REDUCE_BYPASS_EN
            if (carry) begin exp_res = prod[31:0]; exp_lat = 1; end
`endif
            do_req(m, poly, prod, carry, res, err, lat);
            n_vec++; if (res !== exp_res || lat !== exp_lat || err !== 1'b0)
            begin
                n_bad++;
                $display("FAIL random m=%0d c=%b: got %h/%0d/%b want %h/%0d/0",
                         m, carry, res, lat, err, exp_res, exp_lat);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        bus.in_width = WW'(32); bus.in_poly = 32'h8D; bus.in_product = 64'h1234_5678_9ABC_DEF0;
        bus.carry_option = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_ready: got %b want 1", bus.in_ready); end
        n_vec++; if (bus.out_result !== 32'h0) begin n_bad++; $display("FAIL midreset_result: got %h want 0", bus.out_result); end
        repeat (40) begin @(posedge clk); #1; if (bus.out_valid) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_strobe: got %b want 0", seen); end
        test_aes();
    endtask

    task automatic test_bypass();
        logic [31:0] res; logic err; int lat;
        do_req(32, 32'h8D, 64'h1_0000_0003, 1'b1, res, err, lat);
`ifdef GF_REDUCE_BYPASS_EN
        n_vec++; if (res !== 32'h3) begin n_bad++; $display("FAIL bypass_result: got %h want 3", res); end
        n_vec++; if (lat !== 1) begin n_bad++; $display("FAIL bypass_latency: got %0d want 1", lat); end
`else
        n_vec++; if (res !== 32'h8E) begin n_bad++; $display("FAIL bypass_off_result: got %h want 8e", res); end
        n_vec++; if (lat !== 32) begin n_bad++; $display("FAIL bypass_off_latency: got %0d want 32", lat); end
`endif
        n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL bypass_error: got %b want 0", err); end
    endtask

    initial begin
        test_reset();
        test_aes();
        test_back_to_back();
        test_mask();
        test_illegal();
        test_busy_ignore();
        test_random();
        test_reset_mid();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
